// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - halfword-wide load/store sequencer between MEM stage and data memory
//
// Purpose: turns byte/halfword/word loads and stores on a byte address into
// sequences of halfword data-memory accesses. Handles word split, sign/zero
// extension and byte-store read-modify-write. Holds the pipeline through
// BUSY and signals completion with a one-cycle DONE pulse.
//
// Ports:
//   CLK, RST        clock, synchronous active-low reset
//   REQ, WR, SIZE,  request (sampled in IDLE only), store/load select,
//   SIGNED, ADDR,   access size, load extension, byte address,
//   WDATA           right-justified store data
//   RDATA, DONE,    load result and completion pulse,
//   ERR, BUSY       error flag (with DONE), busy in every non-IDLE state
//   MEM_ADDR,       halfword address, write data and write enable to memory,
//   MEM_DI, MEM_WE,
//   MEM_DO          memory read data, one cycle after MEM_ADDR
module load_store_unit #(
  parameter int DATAWIDTH = 16,
  parameter int ADDRBUS   = 20
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   REQ,
  input  logic                   WR,
  input  logic [1:0]             SIZE,
  input  logic                   SIGNED,
  input  logic [ADDRBUS:0]       ADDR,
  input  logic [2*DATAWIDTH-1:0] WDATA,
  output logic [2*DATAWIDTH-1:0] RDATA,
  output logic                   DONE,
  output logic                   ERR,
  output logic                   BUSY,
  output logic [ADDRBUS-1:0]     MEM_ADDR,
  output logic [DATAWIDTH-1:0]   MEM_DI,
  output logic                   MEM_WE,
  input  logic [DATAWIDTH-1:0]   MEM_DO
);

  localparam int WW = 2 * DATAWIDTH;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_LO, S_RD_HI, S_CAP, S_WR_LO, S_WR_HI, S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic                 wr_q, wr_d;
  logic [1:0]           size_q, size_d;
  logic                 sgn_q, sgn_d;
  logic [ADDRBUS-1:0]   haddr_q, haddr_d;
  logic                 bsel_q, bsel_d;
  logic [WW-1:0]        wdata_q, wdata_d;
  logic                 err_q, err_d;
  logic [DATAWIDTH-1:0] lo_q, lo_d;
  logic [DATAWIDTH-1:0] hi_q, hi_d;

  logic                 req_err;
  logic [7:0]           sel_byte;
  logic [DATAWIDTH-1:0] merged;
  logic [WW-1:0]        load_res;

  // Misalignment/illegal size is decided on the live inputs so an errored
  // request never touches memory.
  assign req_err = (SIZE == 2'b11) ||
                   ((SIZE == SZ_HALF) && ADDR[0]) ||
                   ((SIZE == SZ_WORD) && (ADDR[1:0] != 2'b00));

  // Little-endian byte lanes: bsel=0 is bits [7:0].
  assign sel_byte = bsel_q ? lo_q[15:8] : lo_q[7:0];
  assign merged   = bsel_q ? {wdata_q[7:0], lo_q[7:0]} : {lo_q[15:8], wdata_q[7:0]};

  always_comb begin
    load_res = '0;
    case (size_q)
      SZ_BYTE: load_res = {{(WW-8){sgn_q & sel_byte[7]}}, sel_byte};
      SZ_HALF: load_res = {{(WW-DATAWIDTH){sgn_q & lo_q[DATAWIDTH-1]}}, lo_q};
      default: load_res = {hi_q, lo_q};
    endcase
  end

  assign BUSY  = (state_q != S_IDLE);
  assign DONE  = (state_q == S_RESP);
  assign ERR   = (state_q == S_RESP) && err_q;
  assign RDATA = ((state_q == S_RESP) && !wr_q && !err_q) ? load_res : '0;

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    size_d   = size_q;
    sgn_d    = sgn_q;
    haddr_d  = haddr_q;
    bsel_d   = bsel_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    MEM_ADDR = haddr_q;
    MEM_DI   = '0;
    MEM_WE   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (REQ) begin
          wr_d    = WR;
          size_d  = SIZE;
          sgn_d   = SIGNED;
          haddr_d = ADDR[ADDRBUS:1];
          bsel_d  = ADDR[0];
          wdata_d = WDATA;
          err_d   = req_err;
          if (req_err)
            state_d = S_RESP;
          else if (WR && (SIZE != SZ_BYTE))
            state_d = S_WR_LO;
          else
            state_d = S_RD_LO;  // loads and the read half of a byte store
        end
      end
      S_RD_LO: begin
        state_d = (!wr_q && (size_q == SZ_WORD)) ? S_RD_HI : S_CAP;
      end
      S_RD_HI: begin
        MEM_ADDR = haddr_q + ADDRBUS'(1);
        lo_d     = MEM_DO;   // data for the RD_LO address
        state_d  = S_CAP;
      end
      S_CAP: begin
        if (size_q == SZ_WORD)
          hi_d = MEM_DO;
        else
          lo_d = MEM_DO;
        state_d = wr_q ? S_WR_LO : S_RESP;
      end
      S_WR_LO: begin
        MEM_WE  = 1'b1;
        MEM_DI  = (size_q == SZ_BYTE) ? merged : wdata_q[DATAWIDTH-1:0];
        state_d = (size_q == SZ_WORD) ? S_WR_HI : S_RESP;
      end
      S_WR_HI: begin
        MEM_ADDR = haddr_q + ADDRBUS'(1);
        MEM_WE   = 1'b1;
        MEM_DI   = wdata_q[WW-1:DATAWIDTH];
        state_d  = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;    // REQ ignored here: one IDLE cycle always follows
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      haddr_q <= '0;
      bsel_q  <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      haddr_q <= haddr_d;
      bsel_q  <= bsel_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store sequencer between the CPU pipeline's MEM stage and the data memory. Converts pipeline byte-addressed byte/halfword/word loads and stores into sequences of halfword-wide data-memory accesses. It handles word split, sign/zero extension and byte-store read-modify-write, and holds the pipeline via a busy/done handshake.

## Interface
- DATAWIDTH, 16, data-memory word width (halfword); CPU word = 2*DATAWIDTH; byte ops defined for 16 only
- ADDRBUS, 20, data-memory address width (halfword address); CPU byte address = ADDRBUS+1 bits

- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous, active-low reset
- REQ  in  1  access request, sampled only in IDLE
- WR  in  1  1 = store, 0 = load
- SIZE  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- SIGNED  in  1  1 = sign-extend load result, 0 = zero-extend
- ADDR  in  ADDRBUS+1  byte address
- WDATA  in  2*DATAWIDTH  store data, right-justified
- RDATA  out  2*DATAWIDTH  load result, valid while DONE=1
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  valid with DONE; misaligned or illegal SIZE
- BUSY  out  1  high in every state except IDLE
- MEM_ADDR  out  ADDRBUS  halfword address to data memory
- MEM_DI  out  DATAWIDTH  write data to data memory
- MEM_WE  out  1  data-memory write enable
- MEM_DO  in  DATAWIDTH  data-memory read data; 1-cycle latency: address in cycle N, data valid in N+1

## Operation
- Acceptance: in IDLE with REQ=1, latch WR, SIZE, SIGNED, ADDR, WDATA. Derive haddr = ADDR[ADDRBUS:1] and bsel = ADDR[0].
- Error check at acceptance: SIZE=11; halfword with ADDR[0]=1; word with ADDR[1:0]≠00.
  - On error, go straight to RESP with ERR=1.
  - MEM_WE stays 0 and no memory access is made.
- States: IDLE, RD_LO, RD_HI, CAP, WR_LO, WR_HI, RESP.
- RD_LO: MEM_ADDR=haddr, MEM_WE=0.
  - Next state is RD_HI for a word load, else CAP.
- RD_HI: MEM_ADDR=haddr+1; capture MEM_DO into the low-half register. Next state CAP.
- CAP: capture MEM_DO into the high half for a word, else into the low half.
  - Next state is WR_LO for a byte store, else RESP.
- WR_LO: MEM_ADDR=haddr, MEM_WE=1.
  - MEM_DI = WDATA[15:0] for halfword/word.
  - For a byte store, MEM_DI = captured halfword with byte bsel replaced by WDATA[7:0].
  - Next state is WR_HI for a word store, else RESP.
- WR_HI: MEM_ADDR=haddr+1, MEM_WE=1, MEM_DI=WDATA[31:16]. Next state RESP.
- RESP: DONE=1 and ERR valid. Next state IDLE; REQ is ignored in this state.
- Sequences per access type:
  - Byte/halfword load: RD_LO, CAP.
  - Word load: RD_LO, RD_HI, CAP.
  - Halfword store: WR_LO.
  - Word store: WR_LO, WR_HI.
  - Byte store: RD_LO, CAP, WR_LO (read-modify-write).
- Endianness is little-endian.
  - bsel=0 selects bits [7:0] of the halfword; bsel=1 selects [15:8].
  - For a word, the low half is at haddr and the high half at haddr+1.
- Load result:
  - Byte: RDATA = selected byte extended per SIGNED.
  - Halfword: RDATA = halfword extended per SIGNED.
  - Word: RDATA = {hi, lo}; SIGNED is ignored.
- Store: RDATA=0.
- haddr+1 never wraps, because word accesses require an even haddr.
- MEM_ADDR, MEM_DI and MEM_WE are driven from the state and latched request only. In IDLE and RESP, MEM_WE=0.

## Timing
- The REQ-sampling edge is edge 0. DONE is high in the following cycle, counted from edge 0:
  - Error: cycle 1.
  - Halfword store: cycle 2.
  - Byte/halfword load and word store: cycle 3.
  - Word load and byte store: cycle 4.
- Minimum spacing between acceptances is latency+1. At least one IDLE cycle follows every RESP.
- Pipeline stall = REQ & ~DONE. The pipeline holds request inputs stable until DONE; the unit does not depend on that after latching.
- Reset values (RST=0 at an edge): state IDLE; BUSY, DONE, ERR, MEM_WE = 0; RDATA, MEM_ADDR, MEM_DI = 0; all latched registers = 0.
- Reset mid-operation aborts at the next edge with no DONE.
  - A word store reset after WR_LO leaves the low half written; this is accepted behaviour.
- REQ asserted together with RST=0 is ignored.

## Test plan
- Byte load (SIGNED=1): memory[5]=16'h80FF; LB at ADDR=11 → DONE in cycle 3, RDATA=32'hFFFFFF80, no MEM_WE pulses.
- Byte load (SIGNED=0): same LB at ADDR=11 with SIGNED=0 → RDATA=32'h00000080.
- Word store then load: SW WDATA=32'hDEADBEEF at ADDR=8 → MEM_WE in cycles 1–2 writing haddr 4=BEEF, 5=DEAD, DONE in cycle 3; LW at ADDR=8 → DONE in cycle 4, RDATA=32'hDEADBEEF.
- Byte store RMW: memory[2]=16'h1234; SB WDATA=8'hAB at ADDR=5 → single write in cycle 3 of 16'hAB34, DONE in cycle 4; adjacent halfwords unchanged.
- Errors: LH at ADDR=3, SW at ADDR=6, SIZE=11 → each gives DONE+ERR in cycle 1, MEM_WE never asserted, memory unchanged.
- Reset and back-to-back:
  - RST=0 during RD_HI of an LW → next cycle IDLE, BUSY=0, no DONE.
  - REQ held high across RESP → the second request is accepted only on the IDLE edge, and its DONE follows the per-type latency.
